// File: rtl/sp_ctrl_fsm_pkg.sv
// sp_ctrl_fsm_pkg: opcode/func constants, control encodings and state types for the SP sequencer
package sp_ctrl_fsm_pkg;
  localparam logic [5:0] OP_R = 6'd0, OP_ANDI = 6'd1, OP_ORI = 6'd2, OP_ADDI = 6'd3, OP_SUBI = 6'd4,
    OP_LW = 6'd5, OP_SW = 6'd6, OP_BEQ = 6'd7, OP_BNE = 6'd8, OP_LUI = 6'd9, OP_J = 6'd10, OP_JAL = 6'd11;
  localparam logic [5:0] FN_AND = 6'd0, FN_OR = 6'd1, FN_ADD = 6'd2, FN_SUB = 6'd3, FN_SLT = 6'd4,
    FN_SLL = 6'd5, FN_NOR = 6'd6, FN_JR = 6'd7;
  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3, ALU_SLT = 4'd4,
    ALU_SLL = 4'd5, ALU_NOR = 4'd6;
  localparam logic [1:0] PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_REG = 2'd3;
  localparam logic [1:0] WS_RD = 2'd0, WS_RT = 2'd1, WS_RA = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_LUI = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE} state_t;
  typedef enum logic [3:0] {CL_ALU, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_LD, CL_ST, CL_ILL} cls_t;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       imm_sext;
    logic [1:0] reg_wsel;
    logic [1:0] wb_src;
  } fields_t;
  typedef struct packed {
    fields_t f;
    cls_t    cls;
  } dec_t;
  typedef struct packed {
    logic       out_valid;
    fields_t    f;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       illegal;
    logic       mem_err;
  } ctrl_t;
endpackage

// File: rtl/sp_ctrl_fsm_if.sv
// sp_ctrl_fsm_if: instruction handshake, datapath strobes and data-memory port of the sequencer
interface sp_ctrl_fsm_if;
  logic        in_valid;
  logic [31:0] inst;
  logic        rs_eq_rt;
  logic        mem_ready;
  logic        out_valid;
  logic [31:0] ir;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic        imm_sext;
  logic        reg_we;
  logic [1:0]  reg_wsel;
  logic [1:0]  wb_src;
  logic        mem_re;
  logic        mem_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        illegal;
  logic        mem_err;
  modport master (
    output in_valid, inst, rs_eq_rt, mem_ready,
    input  out_valid, ir, alu_op, alu_src_imm, imm_sext, reg_we, reg_wsel, wb_src,
           mem_re, mem_we, pc_we, pc_sel, illegal, mem_err
  );
  modport slave (
    input  in_valid, inst, rs_eq_rt, mem_ready,
    output out_valid, ir, alu_op, alu_src_imm, imm_sext, reg_we, reg_wsel, wb_src,
           mem_re, mem_we, pc_we, pc_sel, illegal, mem_err
  );
endinterface

// File: rtl/sp_ctrl_fsm_decode.sv
// sp_ctrl_fsm_decode: opcode/func -> datapath control fields and instruction class
module sp_ctrl_fsm_decode
  import sp_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);
  // unknown opcodes/funcs fall through to CL_ILL with neutral fields
  always_comb begin
    dec = '0;
    dec.f.alu_op = ALU_ADD;
    dec.f.imm_sext = 1'b1;
    dec.cls = CL_ILL;
    case (op)
      OP_R: begin
        dec.f.alu_op = func <= FN_NOR ? func[3:0] : ALU_ADD;
        dec.cls = func <= FN_NOR ? CL_ALU : func == FN_JR ? CL_JR : CL_ILL;
      end
      OP_ANDI, OP_ORI: begin
        dec.f.alu_op = op == OP_ANDI ? ALU_AND : ALU_OR;
        dec.f.alu_src_imm = 1'b1;
        dec.f.imm_sext = 1'b0;
        dec.f.reg_wsel = WS_RT;
        dec.cls = CL_ALU;
      end
      OP_ADDI, OP_SUBI: begin
        dec.f.alu_op = op == OP_ADDI ? ALU_ADD : ALU_SUB;
        dec.f.alu_src_imm = 1'b1;
        dec.f.reg_wsel = WS_RT;
        dec.cls = CL_ALU;
      end
      OP_LW: begin
        dec.f.alu_src_imm = 1'b1;
        dec.f.reg_wsel = WS_RT;
        dec.f.wb_src = WB_MEM;
        dec.cls = CL_LD;
      end
      OP_SW: begin
        dec.f.alu_src_imm = 1'b1;
        dec.cls = CL_ST;
      end
      OP_BEQ, OP_BNE: begin
        dec.f.alu_op = ALU_SUB;
        dec.cls = op == OP_BEQ ? CL_BEQ : CL_BNE;
      end
      OP_LUI: begin
        dec.f.alu_src_imm = 1'b1;
        dec.f.reg_wsel = WS_RT;
        dec.f.wb_src = WB_LUI;
        dec.cls = CL_ALU;
      end
      OP_J: dec.cls = CL_J;
      OP_JAL: begin
        dec.f.reg_wsel = WS_RA;
        dec.f.wb_src = WB_PC4;
        dec.cls = CL_JAL;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/sp_ctrl_fsm.sv
// sp_ctrl_fsm: multi-cycle control sequencer driving registered datapath and memory strobes
module sp_ctrl_fsm
  import sp_ctrl_fsm_pkg::*;
#(
  parameter int MEM_MAX_WAIT = 8
) (
  input logic           clk,
  input logic           rst_n,
  sp_ctrl_fsm_if.slave  bus
);
  localparam int CW = $clog2(MEM_MAX_WAIT + 1);
  state_t        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  ctrl_t         out_q, out_d;
  dec_t          dec;
  logic          is_mem;
  sp_ctrl_fsm_decode u_dec (.op(ir_q[31:26]), .func(ir_q[5:0]), .dec(dec));
  assign is_mem = dec.cls inside {CL_LD, CL_ST};
  // outputs are computed for the state being entered so every strobe comes straight from a flop
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    cnt_d = cnt_q;
    err_d = err_q;
    out_d = '0;
    case (state_q)
      S_IDLE: if (bus.in_valid) begin
        state_d = S_DECODE;
        ir_d = bus.inst;
      end
      S_DECODE: begin
        state_d = S_EXEC;
        out_d.f = dec.f;
        out_d.reg_we = dec.cls inside {CL_ALU, CL_JAL};
        out_d.pc_we = !is_mem;
        out_d.pc_sel = (dec.cls == CL_BEQ && bus.rs_eq_rt) || (dec.cls == CL_BNE && !bus.rs_eq_rt) ? PC_BR :
                       dec.cls inside {CL_J, CL_JAL} ? PC_JMP : dec.cls == CL_JR ? PC_REG : PC_SEQ;
      end
      S_EXEC: begin
        state_d = is_mem ? S_MEM : S_DONE;
        cnt_d = CW'(1);
        err_d = 1'b0;
        out_d.f = is_mem ? dec.f : fields_t'(0);
        out_d.mem_re = dec.cls == CL_LD;
        out_d.mem_we = dec.cls == CL_ST;
        out_d.out_valid = !is_mem;
        out_d.illegal = dec.cls == CL_ILL;
      end
      S_MEM: begin
        out_d.f = dec.f;
        if (bus.mem_ready || cnt_q == CW'(MEM_MAX_WAIT)) begin
          state_d = S_WB;
          err_d = !bus.mem_ready;
          out_d.reg_we = bus.mem_ready && dec.cls == CL_LD;
          out_d.pc_we = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          out_d.mem_re = dec.cls == CL_LD;
          out_d.mem_we = dec.cls == CL_ST;
        end
      end
      S_WB: begin
        state_d = S_DONE;
        out_d.out_valid = 1'b1;
        out_d.mem_err = err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state, instruction register, wait counter and output flops; reset aborts any instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      out_q <= out_d;
    end
  end
  assign bus.out_valid = out_q.out_valid;
  assign bus.ir = ir_q;
  assign bus.alu_op = out_q.f.alu_op;
  assign bus.alu_src_imm = out_q.f.alu_src_imm;
  assign bus.imm_sext = out_q.f.imm_sext;
  assign bus.reg_we = out_q.reg_we;
  assign bus.reg_wsel = out_q.f.reg_wsel;
  assign bus.wb_src = out_q.f.wb_src;
  assign bus.mem_re = out_q.mem_re;
  assign bus.mem_we = out_q.mem_we;
  assign bus.pc_we = out_q.pc_we;
  assign bus.pc_sel = out_q.pc_sel;
  assign bus.illegal = out_q.illegal;
  assign bus.mem_err = out_q.mem_err;
endmodule
